// File: rtl/l1d_mshr_alloc.sv
// MSHR credit allocator: tracks free MSHR entries, stages one free index on a
// valid/ready credit port and counts outstanding entries.
// Optional build macro L1D_MSHR_ALLOC_CHK_EN drops illegal releases and raises
// a sticky err_bad_release flag.
module l1d_mshr_alloc #(
    parameter int unsigned MSHR_NUM      = 8,
    parameter int unsigned MSHR_ID_WIDTH = $clog2(MSHR_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     alloc_vld,
    input  logic                     alloc_rdy,
    output logic [MSHR_ID_WIDTH-1:0] alloc_index,
    input  logic                     release_vld,
    input  logic [MSHR_ID_WIDTH-1:0] release_index,
    output logic [MSHR_ID_WIDTH:0]   mshr_used_cnt,
    output logic                     mshr_full,
    output logic                     err_bad_release
);

    localparam int unsigned CNT_W = MSHR_ID_WIDTH + 1;

    logic [MSHR_NUM-1:0]      free_map_q, free_map_d;
    logic                     slot_vld_q, slot_vld_d;
    logic [MSHR_ID_WIDTH-1:0] slot_idx_q, slot_idx_d;
    logic [CNT_W-1:0]         used_cnt_q, used_cnt_d;
    logic                     full_q, full_d;
    logic                     err_q, err_d;

    logic                     grant;
    logic                     rel_ok;
    logic                     rel_bad;
    logic                     pick_vld;
    logic [MSHR_ID_WIDTH-1:0] pick_idx;

    assign grant = slot_vld_q && alloc_rdy;

    // Lowest free entry of the current map; an incoming release is not eligible yet.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < int'(MSHR_NUM); i++) begin
            if (!pick_vld && free_map_q[i]) begin
                pick_vld = 1'b1;
                pick_idx = MSHR_ID_WIDTH'(i);
            end
        end
    end

`ifdef L1D_MSHR_ALLOC_CHK_EN
    // A release must name an entry that is neither free nor sitting in the slot.
    always_comb begin
        rel_bad = release_vld &&
                  (free_map_q[release_index] ||
                   (slot_vld_q && (release_index == slot_idx_q)));
        rel_ok  = release_vld && !rel_bad;
    end
`else
    always_comb begin
        rel_bad = 1'b0;
        rel_ok  = release_vld;
    end
`endif

    always_comb begin
        free_map_d = free_map_q;
        slot_vld_d = slot_vld_q;
        slot_idx_d = slot_idx_q;
        used_cnt_d = used_cnt_q;
        err_d      = err_q || rel_bad;

        if (rel_ok) begin
            free_map_d[release_index] = 1'b1;
        end

        // Clear after the release set so the load wins if both hit one bit.
        if (!slot_vld_q || grant) begin
            if (pick_vld) begin
                slot_vld_d           = 1'b1;
                slot_idx_d           = pick_idx;
                free_map_d[pick_idx] = 1'b0;
            end else begin
                slot_vld_d = 1'b0;
            end
        end

        case ({grant, rel_ok})
            2'b10:   used_cnt_d = used_cnt_q + CNT_W'(1);
            2'b01:   used_cnt_d = used_cnt_q - CNT_W'(1);
            default: used_cnt_d = used_cnt_q;
        endcase

        full_d = (used_cnt_d == CNT_W'(MSHR_NUM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map_q <= '1;
            slot_vld_q <= 1'b0;
            slot_idx_q <= '0;
            used_cnt_q <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            slot_vld_q <= slot_vld_d;
            slot_idx_q <= slot_idx_d;
            used_cnt_q <= used_cnt_d;
            full_q     <= full_d;
            err_q      <= err_d;
        end
    end

    assign alloc_vld     = slot_vld_q;
    assign alloc_index   = slot_idx_q;
    assign mshr_used_cnt = used_cnt_q;
    assign mshr_full     = full_q;
`ifdef L1D_MSHR_ALLOC_CHK_EN
    assign err_bad_release = err_q;
`else
    assign err_bad_release = 1'b0;
`endif

endmodule
